// File: rtl/core_bus_ctrl.sv
// core_bus_ctrl: 8051-style multiplexed external bus controller.
// Turns level requests from the memory controller into ALE/PSEN/RD/WR
// bus cycles on P0/P2 and returns registered read data with busy/done.
// Ports: bus_ctrl_mem_ctrl_* (core side), bus_ctrl_p0/p2/ale/psen/rd/wr
// (pins), bus_ctrl_ea_b_i -> bus_ctrl_mem_ctrl_ea_b_o (synchronised).
// Optional macro BUS_CTRL_WAIT_PIN_EN adds bus_ctrl_ext_wait_i, which
// stretches STROBE after the fixed wait count has expired.
module core_bus_ctrl #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        bus_ctrl_clk_i,
    input  logic        bus_ctrl_rst_b_i,
    input  logic [15:0] bus_ctrl_mem_ctrl_addr_i,
    input  logic [7:0]  bus_ctrl_mem_ctrl_data_i,
    input  logic        bus_ctrl_mem_ctrl_ext_rom_rd_b_i,
    input  logic        bus_ctrl_mem_ctrl_ext_ram_rd_b_i,
    input  logic        bus_ctrl_mem_ctrl_ext_ram_wr_b_i,
    output logic [7:0]  bus_ctrl_mem_ctrl_data_o,
    output logic        bus_ctrl_mem_ctrl_ea_b_o,
    output logic        bus_ctrl_busy_o,
    output logic        bus_ctrl_done_o,
    input  logic        bus_ctrl_ea_b_i,
    input  logic [7:0]  bus_ctrl_p0_i,
    output logic [7:0]  bus_ctrl_p0_o,
    output logic        bus_ctrl_p0_oe_o,
    output logic [7:0]  bus_ctrl_p2_o,
    output logic        bus_ctrl_ale_o,
    output logic        bus_ctrl_psen_b_o,
    output logic        bus_ctrl_rd_b_o,
    output logic        bus_ctrl_wr_b_o
`ifdef BUS_CTRL_WAIT_PIN_EN
    ,
    input  logic        bus_ctrl_ext_wait_i
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    localparam logic [1:0] T_ROM = 2'd0;
    localparam logic [1:0] T_RRD = 2'd1;
    localparam logic [1:0] T_WR  = 2'd2;

    localparam logic [2:0] WS = WAIT_STATES[2:0];

    logic [2:0]  state_q, state_n;
    logic [2:0]  cnt_q, cnt_n;
    logic [1:0]  typ_q, typ_n;
    logic [15:0] addr_q, addr_n;
    logic [7:0]  wdata_q, wdata_n;
    logic        ea_s1_q;
    logic        ext_wait;
    logic        strobe_end;
    logic        cap;

    logic [7:0]  p0_n, p2_n;
    logic        oe_n, ale_n, psen_n, rd_n, wr_n;
    logic        busy_n, done_n;

`ifdef BUS_CTRL_WAIT_PIN_EN
    assign ext_wait = bus_ctrl_ext_wait_i;
`else
    assign ext_wait = 1'b0;
`endif

    // Wait pin only matters once the fixed count has run out.
    assign strobe_end = (cnt_q == WS) && !ext_wait;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        typ_n   = typ_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        cap     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!bus_ctrl_mem_ctrl_ext_ram_wr_b_i) begin
                    typ_n   = T_WR;
                    state_n = S_ADDR;
                end else if (!bus_ctrl_mem_ctrl_ext_ram_rd_b_i) begin
                    typ_n   = T_RRD;
                    state_n = S_ADDR;
                end else if (!bus_ctrl_mem_ctrl_ext_rom_rd_b_i) begin
                    typ_n   = T_ROM;
                    state_n = S_ADDR;
                end
                if (state_n == S_ADDR) begin
                    addr_n  = bus_ctrl_mem_ctrl_addr_i;
                    wdata_n = bus_ctrl_mem_ctrl_data_i;
                end
            end
            S_ADDR: state_n = S_LATCH;
            S_LATCH: begin
                state_n = S_STROBE;
                cnt_n   = 3'd0;
            end
            S_STROBE: begin
                if (strobe_end) begin
                    state_n = S_HOLD;
                    cap     = (typ_q != T_WR);
                end else if (cnt_q != WS) begin
                    cnt_n = cnt_q + 3'd1;
                end
            end
            S_HOLD: begin
                state_n = S_IDLE;
                cnt_n   = 3'd0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Pin values for the state being entered, so every pin is a flop.
    always_comb begin
        ale_n  = 1'b0;
        psen_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        oe_n   = 1'b0;
        p0_n   = 8'h00;
        p2_n   = 8'hFF;
        busy_n = 1'b0;
        done_n = 1'b0;
        unique case (state_n)
            S_ADDR: begin
                ale_n  = 1'b1;
                oe_n   = 1'b1;
                p0_n   = addr_n[7:0];
                p2_n   = addr_n[15:8];
                busy_n = 1'b1;
            end
            S_LATCH: begin
                oe_n   = 1'b1;
                p0_n   = addr_n[7:0];
                p2_n   = addr_n[15:8];
                busy_n = 1'b1;
            end
            S_STROBE: begin
                p2_n   = addr_n[15:8];
                busy_n = 1'b1;
                if (typ_n == T_ROM) psen_n = 1'b0;
                if (typ_n == T_RRD) rd_n = 1'b0;
                if (typ_n == T_WR) begin
                    wr_n = 1'b0;
                    oe_n = 1'b1;
                    p0_n = wdata_n;
                end
            end
            S_HOLD: begin
                p2_n   = addr_n[15:8];
                busy_n = 1'b1;
                done_n = 1'b1;
                if (typ_n == T_WR) begin
                    oe_n = 1'b1;
                    p0_n = wdata_n;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge bus_ctrl_clk_i or negedge bus_ctrl_rst_b_i) begin
        if (!bus_ctrl_rst_b_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            typ_q   <= T_ROM;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            bus_ctrl_ale_o    <= 1'b0;
            bus_ctrl_psen_b_o <= 1'b1;
            bus_ctrl_rd_b_o   <= 1'b1;
            bus_ctrl_wr_b_o   <= 1'b1;
            bus_ctrl_p0_oe_o  <= 1'b0;
            bus_ctrl_p0_o     <= 8'h00;
            bus_ctrl_p2_o     <= 8'hFF;
            bus_ctrl_busy_o   <= 1'b0;
            bus_ctrl_done_o   <= 1'b0;
            bus_ctrl_mem_ctrl_data_o <= 8'h00;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            typ_q   <= typ_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            bus_ctrl_ale_o    <= ale_n;
            bus_ctrl_psen_b_o <= psen_n;
            bus_ctrl_rd_b_o   <= rd_n;
            bus_ctrl_wr_b_o   <= wr_n;
            bus_ctrl_p0_oe_o  <= oe_n;
            bus_ctrl_p0_o     <= p0_n;
            bus_ctrl_p2_o     <= p2_n;
            bus_ctrl_busy_o   <= busy_n;
            bus_ctrl_done_o   <= done_n;
            if (cap) begin
                bus_ctrl_mem_ctrl_data_o <= bus_ctrl_p0_i;
            end
        end
    end

    always_ff @(posedge bus_ctrl_clk_i or negedge bus_ctrl_rst_b_i) begin
        if (!bus_ctrl_rst_b_i) begin
            ea_s1_q                  <= 1'b1;
            bus_ctrl_mem_ctrl_ea_b_o <= 1'b1;
        end else begin
            ea_s1_q                  <= bus_ctrl_ea_b_i;
            bus_ctrl_mem_ctrl_ea_b_o <= ea_s1_q;
        end
    end

endmodule
